// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM state
// encoding, port index constants and default widths.
package data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_DBG = 1;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 6;

endpackage

// File: rtl/data_mem_arbiter_pick.sv
// Winner selection for the data memory arbiter. Purely combinational.
// Build option: MEMARB_ROUND_ROBIN_EN selects round-robin arbitration
// (tie goes to the port not granted last); otherwise fixed priority with
// port 0 always winning and the last-granted input ignored.
module mem_arb_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

`ifdef MEMARB_ROUND_ROBIN_EN
   // On a tie favour the port that did not win last; a lone requester wins outright.
   always_comb begin
      if (req == 2'b11) begin
         grant = ~last;
      end else begin
         grant = req[1] & ~req[0];
      end
   end
`else
   // Fixed priority: the CPU port wins whenever it asks.
   logic unused_last;
   assign unused_last = last;
   assign grant       = req[1] & ~req[0];
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (CPU on port 0,
// debug/loader on port 1). Each access takes IDLE -> ACCESS -> RESP, so a
// continuously requesting port gets one access every three cycles.
// Build option: MEMARB_ROUND_ROBIN_EN enables round-robin arbitration and the
// last-granted pointer; without it port 0 has fixed priority.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic [1:0]            ack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   state_t state;
   logic   owner;
   logic   grant;
   logic   last_grant;

   mem_arb_pick u_pick (
      .req   (req),
      .last  (last_grant),
      .grant (grant)
   );

`ifdef MEMARB_ROUND_ROBIN_EN
   // Remember who won at each grant so the next tie goes the other way.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (state == IDLE && req != 2'b00) begin
         last_grant <= grant;
      end
   end
`else
   assign last_grant = 1'b1;
`endif

   // Access FSM; the memory strobes, ack and rdata are all registered here.
   // NOTE: every output is cleared by the asynchronous reset, so pulling rst_n
   // low mid-ACCESS drops mem_write before the next edge and the write is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= 1'b0;
         ack       <= 2'b00;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_data  <= '0;
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments everywhere so every register samples
         // pre-edge values regardless of statement order.
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  state     <= ACCESS;
                  owner     <= grant;
                  mem_addr  <= grant ? addr1 : addr0;
                  mem_data  <= grant ? wdata1 : wdata0;
                  mem_write <= we[grant];
                  mem_read  <= ~we[grant];
               end
            end
            ACCESS: begin
               state     <= RESP;
               if (mem_read) begin
                  rdata <= mem_q;
               end
               ack       <= owner ? 2'b10 : 2'b01;
               mem_addr  <= '0;
               mem_data  <= '0;
               mem_write <= 1'b0;
               mem_read  <= 1'b0;
            end
            RESP: begin
               state <= IDLE;
               ack   <= 2'b00;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter. Works for both builds; the
// expected winner follows MEMARB_ROUND_ROBIN_EN when it is defined.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req, we;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic [1:0]    ack;
   logic [DW-1:0] rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_write, mem_read;
   logic [DW-1:0] mem_q;

   // Data memory device: combinational read, write on a clean rising edge.
   logic [DW-1:0] mem [64];
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [DW-1:0] load_data;

   // Reference model state.
   logic [DW-1:0] ref_mem [64];
   logic [DW-1:0] ref_rdata;
   int            ref_last;

   int tests = 0;
   int fails = 0;
   int cyc_count = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack       (ack),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .mem_q     (mem_q)
   );

   assign mem_q = mem[mem_addr];

   always @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
      else if (rst_n && mem_write) mem[mem_addr] <= mem_data;
   end

   always @(posedge clk) cyc_count <= cyc_count + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Winner predicted from the arbitration rules of the current build.
   function automatic int exp_winner(input logic [1:0] r);
`ifdef MEMARB_ROUND_ROBIN_EN
      if (r == 2'b11) return 1 - ref_last;
`endif
      return r[0] ? 0 : 1;
   endfunction

   task automatic model_reset();
      ref_last  = 1;
      ref_rdata = '0;
   endtask

   // One arbitrated transaction from an idle FSM: present pattern pat, wait for
   // the single resulting ack, then check grant, latency, strobes and rdata.
   task automatic txn(input logic [1:0] pat, input logic [1:0] w,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input string tag);
      logic [1:0]    got, exp_ack;
      logic [AW-1:0] seen_a, wa;
      logic [DW-1:0] seen_d, wd;
      int            lat, wcnt, rcnt, win;
      got = '0; lat = 0; wcnt = 0; rcnt = 0; seen_a = '0; seen_d = '0;
      win     = exp_winner(pat);
      wa      = (win == 1) ? a1 : a0;
      wd      = (win == 1) ? d1 : d0;
      exp_ack = (win == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; req = pat;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (mem_write || mem_read) begin
            seen_a = mem_addr;
            seen_d = mem_data;
         end
         wcnt += int'(mem_write);
         rcnt += int'(mem_read);
         if (ack != 2'b00) begin
            got = ack;
            lat = i;
            break;
         end
      end
      ref_last = win;
      if (w[win]) ref_mem[wa] = wd;
      else        ref_rdata   = ref_mem[wa];
      check({tag, "_ack"},     64'(got),  64'(exp_ack));
      check({tag, "_latency"}, 64'(lat),  64'd2);
      check({tag, "_wr_cyc"},  64'(wcnt), 64'(w[win]));
      check({tag, "_rd_cyc"},  64'(rcnt), 64'(!w[win]));
      check({tag, "_addr"},    64'(seen_a), 64'(wa));
      check({tag, "_data"},    64'(seen_d), 64'(wd));
      check({tag, "_rdata"},   64'(rdata),  64'(ref_rdata));
      @(negedge clk);
      req = 2'b00;
      @(posedge clk); #1;
      check({tag, "_ack_clr"}, 64'(ack), 64'd0);
   endtask

   initial begin
      int            n, prev, win;
      logic [DW-1:0] v;

      rst_n = 1'b0; req = '0; we = '0; addr0 = '0; addr1 = '0;
      wdata0 = '0; wdata1 = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
      model_reset();

      // Preload the memory during reset; the model gets the same contents.
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         v = $urandom;
         load_en = 1'b1; load_addr = AW'(i); load_data = v;
         ref_mem[i] = v;
      end
      @(negedge clk);
      load_en = 1'b0;

      // Reset state.
      check("rst_ack",   64'(ack),   64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_mem",   64'({mem_addr, mem_write, mem_read}), 64'd0);
      check("rst_wdat",  64'(mem_data), 64'd0);
      check("rst_state", 64'(dut.state), 64'd0);
      rst_n = 1'b1;

      // Idle bus for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("idle_bus", 64'({ack, mem_read, mem_write, mem_addr, mem_data}), 64'd0);
      end

      // Single write then single read on port 0.
      txn(2'b01, 2'b01, 6'd5, 6'd0, 32'hDEADBEEF, 32'h0, "wr5");
      txn(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0, "rd5");
      check("rd5_value", 64'(rdata), 64'h0000_0000_DEAD_BEEF);

      // Back-to-back stream: port 1 reads addrs 0..3 with req held high.
      @(negedge clk);
      we = 2'b00; addr1 = '0; req = 2'b10;
      n = 0; prev = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(posedge clk); #1;
         if (ack[1]) begin
            ref_rdata = ref_mem[n];
            ref_last  = 1;
            check("stream_rdata", 64'(rdata), 64'(ref_rdata));
            if (n > 0) check("stream_gap", 64'(cyc_count - prev), 64'd3);
            prev = cyc_count;
            n++;
            if (n < 4) addr1 = AW'(n);
            else       req = 2'b00;
         end
      end
      check("stream_count", 64'(n), 64'd4);
      @(negedge clk);
      @(negedge clk);

      // Write after a read leaves rdata at the read value.
      txn(2'b01, 2'b01, 6'd20, 6'd0, 32'hCAFE_0001, 32'h0, "wr_hold");
      check("wr_hold_keep", 64'(rdata), 64'(ref_mem[3]));

      // Fresh reset, then both ports request together for two grants.
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      we = 2'b00; addr0 = 6'd10; addr1 = 6'd11; req = 2'b11;
      n = 0;
      for (int i = 0; i < 30 && n < 2; i++) begin
         @(posedge clk); #1;
         if (ack != 2'b00) begin
            win = exp_winner(2'b11);
            check("tie_grant", 64'(ack), (win == 1) ? 64'd2 : 64'd1);
            ref_last  = win;
            ref_rdata = ref_mem[(win == 1) ? 11 : 10];
            check("tie_rdata", 64'(rdata), 64'(ref_rdata));
            n++;
            if (n == 2) req = 2'b00;
         end
      end
      check("tie_count", 64'(n), 64'd2);
      @(negedge clk);
      @(negedge clk);

      // Randomized traffic, including simultaneous requests.
      for (int i = 0; i < 24; i++) begin
         txn(2'($urandom_range(1, 3)), 2'($urandom), 6'($urandom), 6'($urandom),
             $urandom, $urandom, "rnd");
      end

      // Reset in the middle of port 0's write to addr 9.
      @(negedge clk);
      we = 2'b01; addr0 = 6'd9; wdata0 = 32'h1234_5678; req = 2'b01;
      @(posedge clk); #1;
      check("rst_mid_wr_active", 64'(mem_write), 64'd1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_mid_ctl", 64'({ack, mem_read, mem_write, mem_addr}), 64'd0);
      check("rst_mid_data", 64'({rdata, mem_data}), 64'd0);
      check("rst_mid_state", 64'(dut.state), 64'd0);
      req = 2'b00;
      @(posedge clk); #1;
      check("rst_mid_mem9", 64'(mem[9]), 64'(ref_mem[9]));
      check("rst_mid_state_hold", 64'(dut.state), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // After reset the block works normally again.
      txn(2'b01, 2'b00, 6'd9, 6'd0, 32'h0, 32'h0, "post_rst_rd9");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
